// File: rtl/control_fsm_if.sv
// ============================================================================
//  Module   : control_fsm_if
//  Brief    : Memory bus handshake bundle between the control path (master)
//             and the memory subsystem (slave).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface control_fsm_if;
  logic mem_req;       // access request, held until mem_ack
  logic mem_we;        // write qualifier for mem_req
  logic mem_addr_sel;  // 0 = PC address, 1 = datapath address
  logic mem_ack;       // memory completes current access this cycle

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ack
  );
endinterface

`default_nettype wire

// File: rtl/control_fsm.sv
// ============================================================================
//  Module   : control_fsm
//  Brief    : Multi-cycle CPU control path. FETCH -> DECODE -> EXECUTE ->
//             (MEM) -> WRITEBACK, with memory wait states, a bus timeout,
//             ALU-fault halt and a sticky halt cause.
//  Options  : CTRL_SINGLE_STEP_EN adds step_mode/step single-instruction
//             stepping; undefined builds run free.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module control_fsm #(
  parameter int                  INSTR_W  = 16,
  parameter int                  OPCODE_W = 4,
  parameter logic [OPCODE_W-1:0] OP_HALT  = 4'hF,
  parameter logic [OPCODE_W-1:0] OP_LOAD  = 4'h8,
  parameter logic [OPCODE_W-1:0] OP_STORE = 4'h9,
  parameter logic [OPCODE_W-1:0] OP_JMP   = 4'hA,
  parameter int                  TIMEOUT  = 255
) (
  input  wire logic               clock,
  input  wire logic               reset,
`ifdef CTRL_SINGLE_STEP_EN
  input  wire logic               step_mode,
  input  wire logic               step,
`endif
  input  wire logic [INSTR_W-1:0] instruction,
  input  wire logic               alu_fault,
  control_fsm_if.master           bus,
  output logic                    ir_load,
  output logic                    alu_en,
  output logic                    reg_we,
  output logic                    pc_inc,
  output logic                    pc_load,
  output logic [2:0]              state,
  output logic                    halted,
  output logic [1:0]              fault
);

  localparam int                 CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   C_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [1:0]         C_FLT_NONE = 2'd0;
  localparam logic [1:0]         C_FLT_ALU  = 2'd1;
  localparam logic [1:0]         C_FLT_BUS  = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [1:0]         r_fault;
  logic [1:0]         w_fault_nxt;

  logic               w_mem_req;
  logic               w_mem_we;
  logic               w_mem_addr_sel;
  logic               w_ir_load;
  logic               w_alu_en;
  logic               w_reg_we;
  logic               w_pc_inc;
  logic               w_pc_load;
  logic               w_hold;

  logic [OPCODE_W-1:0] w_opcode;
  logic                w_is_store;
  logic                w_is_jmp;
  logic                w_is_mem_op;
  logic                w_unused_operand;

  assign w_opcode         = instruction[INSTR_W-1 -: OPCODE_W];
  assign w_is_store       = (w_opcode == OP_STORE);
  assign w_is_jmp         = (w_opcode == OP_JMP);
  assign w_is_mem_op      = (w_opcode == OP_LOAD) || w_is_store;
  // Operand bits belong to the datapath; the control path only decodes the opcode.
  assign w_unused_operand = ^instruction[INSTR_W-OPCODE_W-1:0];

`ifdef CTRL_SINGLE_STEP_EN
  logic r_step_d;
  logic r_go;
  logic w_step_rise;
  logic w_fetch_done;

  assign w_step_rise  = step & ~r_step_d;
  assign w_hold       = step_mode && (r_state == S_FETCH) && !(r_go || w_step_rise);
  assign w_fetch_done = (r_state == S_FETCH) && !w_hold && bus.mem_ack;

  // Step edge detector and one-instruction grant, consumed when the fetch completes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_step_d <= 1'b0;
      r_go     <= 1'b0;
    end else begin
      r_step_d <= step;
      if (w_fetch_done) begin
        r_go <= 1'b0;
      end else if (step_mode && w_step_rise) begin
        r_go <= 1'b1;
      end
    end
  end
`else
  assign w_hold = 1'b0;
`endif

  // State, wait-cycle counter and sticky halt cause.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_fault <= C_FLT_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  // Next-state, counter and Moore strobe decode qualified by mem_ack/opcode.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_fault_nxt    = r_fault;
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr_sel = 1'b0;
    w_ir_load      = 1'b0;
    w_alu_en       = 1'b0;
    w_reg_we       = 1'b0;
    w_pc_inc       = 1'b0;
    w_pc_load      = 1'b0;
    case (r_state)
      S_FETCH: begin
        // While held for a step pulse the request is withdrawn and the counter frozen.
        if (!w_hold) begin
          w_mem_req = 1'b1;
          if (bus.mem_ack) begin
            w_ir_load   = 1'b1;
            w_state_nxt = S_DECODE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_TIMEOUT) begin
            w_state_nxt = S_HALT;
            w_cnt_nxt   = '0;
            w_fault_nxt = C_FLT_BUS;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_DECODE: begin
        w_cnt_nxt = '0;
        if (w_opcode == OP_HALT) begin
          w_state_nxt = S_HALT;
          w_fault_nxt = C_FLT_NONE;
        end else begin
          w_state_nxt = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        w_alu_en  = 1'b1;
        w_cnt_nxt = '0;
        if (alu_fault) begin
          w_state_nxt = S_HALT;
          w_fault_nxt = C_FLT_ALU;
        end else if (w_is_mem_op) begin
          w_state_nxt = S_MEM;
        end else begin
          w_state_nxt = S_WRITEBACK;
        end
      end
      S_MEM: begin
        w_mem_req      = 1'b1;
        w_mem_addr_sel = 1'b1;
        w_mem_we       = w_is_store;
        if (bus.mem_ack) begin
          w_state_nxt = S_WRITEBACK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_TIMEOUT) begin
          w_state_nxt = S_HALT;
          w_cnt_nxt   = '0;
          w_fault_nxt = C_FLT_BUS;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WRITEBACK: begin
        w_reg_we    = !(w_is_store || w_is_jmp);
        w_pc_load   = w_is_jmp;
        w_pc_inc    = !w_is_jmp;
        w_state_nxt = S_FETCH;
        w_cnt_nxt   = '0;
      end
      S_HALT: begin
        w_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt = S_FETCH;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Request-side strobes are gated by reset so an in-flight access drops without waiting for a clock.
  assign bus.mem_req      = w_mem_req & reset;
  assign bus.mem_we       = w_mem_we & reset;
  assign bus.mem_addr_sel = w_mem_addr_sel;
  assign ir_load          = w_ir_load & reset;
  assign alu_en           = w_alu_en;
  assign reg_we           = w_reg_we;
  assign pc_inc           = w_pc_inc;
  assign pc_load          = w_pc_load;
  assign state            = r_state;
  assign halted           = (r_state == S_HALT);
  assign fault            = r_fault;

endmodule

`default_nettype wire
